mmcm_phase_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the phase-shift write port of the MMCM phase-counter wrapper (ps_we / ps_din / ps_ready / ps_dout). It shares that port among NUM_REQ requesters, for example the memory-controller read-level, write-level and sensor-clock tuners. Each requester asks for an absolute phase or a signed relative step. The block issues one write, waits for the phase change to complete, then returns a one-cycle ack carrying the resulting phase. Everything runs in the psclk domain.

---
 rtl/mmcm_phase_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mmcm_phase_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_phase_arbiter.sv
// Round-robin arbiter/sequencer sharing the MMCM phase-shift write port among NUM_REQ requesters.
// Latency: grant to one-cycle ack is the ps_we handshake plus the counter's shift time; one op in flight.
// Backpressure: grants only while ps_ready=1; ps_we held until accepted. Timeout via MMCM_PHASE_ARB_TIMEOUT_EN.
module mmcm_phase_arbiter #(
  parameter int PHASE_WIDTH    = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           psclk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             rel,
  input  logic [NUM_REQ*PHASE_WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           err,
  output logic [PHASE_WIDTH-1:0]         res_phase,
  output logic                           busy,
  output logic [2:0]                     grant_idx,
  output logic                           ps_we,
  output logic [PHASE_WIDTH-1:0]         ps_din,
  input  logic                           ps_ready,
  input  logic [PHASE_WIDTH-1:0]         ps_dout
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mmcm_phase_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mmcm_phase_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ACK
  } state_t;

  state_t                 state;
  logic [2:0]             last_grant;
  logic [7:0]             req_ext;
  logic [7:0]             rel_ext;
  logic [PHASE_WIDTH-1:0] din_arr [8];
  logic                   pick_vld;
  logic [2:0]             pick_idx;
  logic [3:0]             scan;
  logic [PHASE_WIDTH-1:0] target;
  logic [NUM_REQ-1:0]     ack_onehot;

  // Pad the request side out to 8 lanes so the scan can index with a fixed 3-bit value.
  for (genvar g = 0; g < 8; g++) begin : g_din
    if (g < NUM_REQ) begin : g_used
      assign din_arr[g] = din[g*PHASE_WIDTH +: PHASE_WIDTH];
    end else begin : g_pad
      assign din_arr[g] = '0;
    end
  end

  always_comb begin
    req_ext = '0;
    rel_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    rel_ext[NUM_REQ-1:0] = rel;
  end

  // First active request at or after last_grant+1, wrapping at NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, last_grant} + 4'd1 + 4'(k);
      if (scan >= 4'(NUM_REQ)) scan = scan - 4'(NUM_REQ);
      if (!pick_vld && req_ext[scan[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[2:0];
      end
    end
  end

  // Relative steps wrap modulo 2^PHASE_WIDTH by design.
  assign target     = rel_ext[pick_idx] ? (ps_dout + din_arr[pick_idx]) : din_arr[pick_idx];
  assign ack_onehot = NUM_REQ'(1) << grant_idx;

`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (state == S_ISSUE || state == S_WAIT_LOW || state == S_WAIT_HIGH) &&
                  (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge psclk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ack        <= '0;
      res_phase  <= '0;
      busy       <= 1'b0;
      grant_idx  <= '0;
      ps_we      <= 1'b0;
      ps_din     <= '0;
      last_grant <= 3'(NUM_REQ - 1);
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
      err        <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      ack <= '0;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
      err <= 1'b0;
      if (state == S_ISSUE || state == S_WAIT_LOW || state == S_WAIT_HIGH) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_hit) begin
        ps_we     <= 1'b0;
        ack       <= ack_onehot;
        err       <= 1'b1;
        res_phase <= ps_dout;
        state     <= S_ACK;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (ps_ready && pick_vld) begin
            grant_idx <= pick_idx;
            ps_din    <= target;
            ps_we     <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (ps_ready) begin
            ps_we <= 1'b0;
            state <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!ps_ready) state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (ps_ready) begin
            ack       <= ack_onehot;
            res_phase <= ps_dout;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          busy       <= 1'b0;
          last_grant <= grant_idx;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_phase_arbiter.sv
// Directed bench for mmcm_phase_arbiter with a behavioural phase-counter peer.
module tb_mmcm_phase_arbiter;

  localparam int SHIFT_LEN = 3;

  logic        psclk = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  req   = '0;
  logic [3:0]  rel   = '0;
  logic [31:0] din   = '0;
  logic [3:0]  ack;
  logic        err;
  logic [7:0]  res_phase;
  logic        busy;
  logic [2:0]  grant_idx;
  logic        ps_we;
  logic [7:0]  ps_din;
  logic        ps_ready;
  logic [7:0]  ps_dout;

  int   total = 0;
  int   bad   = 0;
  bit   unlock   = 1'b0;
  bit   hold_low = 1'b0;
  logic [7:0] pc_phase;
  int   pc_cnt;
  int   we_cnt = 0;
  logic [7:0] last_we_din = '0;

  mmcm_phase_arbiter #(
    .PHASE_WIDTH(8),
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .psclk(psclk),
    .rst(rst),
    .req(req),
    .rel(rel),
    .din(din),
    .ack(ack),
    .err(err),
    .res_phase(res_phase),
    .busy(busy),
    .grant_idx(grant_idx),
    .ps_we(ps_we),
    .ps_din(ps_din),
    .ps_ready(ps_ready),
    .ps_dout(ps_dout)
  );

  always #5 psclk = ~psclk;

  // Phase counter: accepts on ps_we && ps_ready, then stays busy SHIFT_LEN cycles.
  assign ps_ready = !unlock && (pc_cnt == 0);
  assign ps_dout  = pc_phase;

  always @(posedge psclk or posedge rst) begin
    if (rst) begin
      pc_phase <= '0;
      pc_cnt   <= 0;
    end else if (ps_we && ps_ready) begin
      pc_phase <= ps_din;
      pc_cnt   <= SHIFT_LEN;
    end else if (pc_cnt != 0 && !hold_low) begin
      pc_cnt <= pc_cnt - 1;
    end
  end

  always @(posedge psclk) begin
    if (ps_we) begin
      we_cnt      <= we_cnt + 1;
      last_we_din <= ps_din;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge psclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max, output logic [3:0] a);
    a = '0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (ack != 4'b0000) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic run_op(input int r, input logic rl, input logic [7:0] d,
                        input logic [7:0] exp_v, input string tag);
    logic [3:0] a;
    int w0;
    rel[r] = rl;
    din[r*8 +: 8] = d;
    w0 = we_cnt;
    req[r] = 1'b1;
    wait_ack(60, a);
    check({tag, " ack"}, 32'(a), 32'(4'b0001 << r));
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " res_phase"}, 32'(res_phase), 32'(exp_v));
    check({tag, " ps_din"}, 32'(last_we_din), 32'(exp_v));
    check({tag, " we_cycles"}, 32'(we_cnt - w0), 32'd1);
    check({tag, " grant_idx"}, 32'(grant_idx), 32'(r));
    req[r] = 1'b0;
    tick();
    check({tag, " busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    int  n;
    bit  seen;

    // Reset state
    tick();
    tick();
    check("rst ack", 32'(ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ps_we", 32'(ps_we), 32'd0);
    check("rst ps_din", 32'(ps_din), 32'd0);
    check("rst res_phase", 32'(res_phase), 32'd0);
    check("rst grant_idx", 32'(grant_idx), 32'd0);
    check("rst err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Absolute write, then relative steps wrapping both ways
    run_op(0, 1'b0, 8'h10, 8'h10, "abs0");
    tick();
    tick();
    check("res_hold", 32'(res_phase), 32'h10);
    run_op(0, 1'b0, 8'hFE, 8'hFE, "abs_fe");
    run_op(1, 1'b1, 8'h05, 8'h03, "rel_up");
    run_op(1, 1'b1, 8'hFB, 8'hFE, "rel_dn");

    // Last grant 1: req 0 and 2 together -> 2 then 0
    rel = '0;
    din = 32'h0030_0020;
    req = 4'b0101;
    wait_ack(60, a);
    check("rr02 first", 32'(a), 32'b0100);
    check("rr02 first res", 32'(res_phase), 32'h30);
    req[2] = 1'b0;
    wait_ack(60, a);
    check("rr02 second", 32'(a), 32'b0001);
    check("rr02 second res", 32'(res_phase), 32'h20);
    req[0] = 1'b0;
    tick();

    // Fresh reset, all four requesting -> 0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    din = 32'h4433_2211;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(60, a);
      check("fair order", 32'(a), 32'(4'b0001 << i));
      check("fair res", 32'(res_phase), 32'(8'h11 * (i + 1)));
      req = req & ~a;
    end
    tick();

    // Counter unlocked: no activity until ps_ready rises
    unlock = 1'b1;
    din[23:16] = 8'h55;
    req[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (ps_we || busy) seen = 1'b1;
    end
    check("unlocked idle", 32'(seen), 32'd0);
    unlock = 1'b0;
    tick();
    check("relock ps_we", 32'(ps_we), 32'd1);
    check("relock busy", 32'(busy), 32'd1);
    check("relock grant", 32'(grant_idx), 32'd2);
    wait_ack(60, a);
    check("relock ack", 32'(a), 32'b0100);
    check("relock res", 32'(res_phase), 32'h55);
    req[2] = 1'b0;
    tick();

    // Counter never returns to ready after accepting the write
    hold_low = 1'b1;
    din[15:8] = 8'h66;
    req[1] = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("stall grant", 32'(busy), 32'd1);
    n = 0;
    a = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (ack != 4'b0000) begin
        a = ack;
        break;
      end
    end
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
    check("timeout ack", 32'(a), 32'b0010);
    check("timeout cycles", 32'(n), 32'd16);
    check("timeout err", 32'(err), 32'd1);
    check("timeout res", 32'(res_phase), 32'h66);
    check("timeout ps_we", 32'(ps_we), 32'd0);
    req[1] = 1'b0;
    tick();
    hold_low = 1'b0;
    n = 0;
    while (!ps_ready && n < 20) begin
      tick();
      n++;
    end
    hold_low = 1'b1;
    din[23:16] = 8'h77;
    req[2] = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) tick();
`else
    check("no timeout ack", 32'(a), 32'd0);
    check("no timeout busy", 32'(busy), 32'd1);
    check("no timeout ps_we", 32'(ps_we), 32'd0);
`endif

    // Reset while waiting for the shift to finish
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ps_we", 32'(ps_we), 32'd0);
    check("midrst ack", 32'(ack), 32'd0);
    req = '0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ack != 4'b0000) seen = 1'b1;
    end
    check("midrst no ack", 32'(seen), 32'd0);
    rst = 1'b0;
    hold_low = 1'b0;
    tick();

    din = 32'h0900_0001;
    rel = '0;
    req = 4'b1001;
    wait_ack(60, a);
    check("postrst first", 32'(a), 32'b0001);
    check("postrst first res", 32'(res_phase), 32'h01);
    req[0] = 1'b0;
    wait_ack(60, a);
    check("postrst second", 32'(a), 32'b1000);
    check("postrst second res", 32'(res_phase), 32'h09);
    req[3] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
